// File: rtl/instr_sequencer_pkg.sv
// Shared types for the program sequencer: opcodes, branch conditions,
// FSM states and ALU flag bit positions.
package instr_sequencer_pkg;

    localparam int INSTR_W = 12;
    localparam int CTRL_W  = 10;
    localparam int FLAG_W  = 6;

    // flag vector order is {z,n,vn,vp,br,c}
    localparam int FLAG_Z  = 5;
    localparam int FLAG_N  = 4;
    localparam int FLAG_VN = 3;
    localparam int FLAG_VP = 2;
    localparam int FLAG_BR = 1;
    localparam int FLAG_C  = 0;

    typedef enum logic [1:0] {
        OPC_OP,
        OPC_BR,
        OPC_JMP,
        OPC_HALT
    } opcode_e;

    typedef enum logic [2:0] {
        COND_ALWAYS,
        COND_Z,
        COND_NZ,
        COND_N,
        COND_NN,
        COND_C,
        COND_VP,
        COND_VN
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    function automatic logic cond_met(cond_e c, logic [FLAG_W-1:0] f);
        logic r;
        r = 1'b0;
        unique case (c)
            COND_ALWAYS: r = 1'b1;
            COND_Z:      r = f[FLAG_Z];
            COND_NZ:     r = !f[FLAG_Z];
            COND_N:      r = f[FLAG_N];
            COND_NN:     r = !f[FLAG_N];
            COND_C:      r = f[FLAG_C];
            COND_VP:     r = f[FLAG_VP];
            COND_VN:     r = f[FLAG_VN];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/program-load bundle between the sequencer and its host/datapath.
interface instr_sequencer_if
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W = 5
);
    logic               start;
    logic               step;
    logic               load_we;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic [FLAG_W-1:0]  flags_in;
    logic [CTRL_W-1:0]  ctrl_word;
    logic               ctrl_valid;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               halted;

    modport master (
        output start, step, load_we, load_addr, load_data, flags_in,
        input  ctrl_word, ctrl_valid, pc, busy, halted
    );

    modport slave (
        input  start, step, load_we, load_addr, load_data, flags_in,
        output ctrl_word, ctrl_valid, pc, busy, halted
    );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: one write port, one registered read port,
// write-first when both ports hit the same word.
module prog_mem #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int WIDTH  = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && waddr == raddr) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 12-bit instructions and issues one
// qualified 10-bit control word per OP to the register/ALU datapath.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    instr_sequencer_if.slave  bus
);

    state_e             state;
    logic               run;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [ADDR_W-1:0]  tgt_q;
    opcode_e            op_q;
    cond_e              cond_q;
    logic [FLAG_W-1:0]  flag_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic               valid_q;
    logic               busy_q;
    logic               halted_q;
    logic [INSTR_W-1:0] rdata;
    opcode_e            rd_op;
    logic               idle;
    logic               mem_we;

    assign idle   = (state == ST_IDLE) || (state == ST_HALT);
    assign mem_we = bus.load_we && idle;
    assign rd_op  = opcode_e'(rdata[INSTR_W-1:INSTR_W-2]);

    // The read port is addressed with next pc so the word is ready in FETCH
    // and the control outputs can be registered on the FETCH->EXEC edge.
    always_comb begin
        pc_nxt = pc;
        unique case (state)
            ST_IDLE, ST_HALT: begin
                if (bus.start) pc_nxt = '0;
            end
            ST_FETCH: pc_nxt = pc;
            ST_EXEC: begin
                unique case (op_q)
                    OPC_OP:   pc_nxt = pc + ADDR_W'(1);
                    OPC_BR:   pc_nxt = cond_met(cond_q, flag_q) ?
                                       tgt_q : pc + ADDR_W'(1);
                    OPC_JMP:  pc_nxt = tgt_q;
                    OPC_HALT: pc_nxt = pc;
                endcase
            end
        endcase
    end

    prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (INSTR_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (bus.load_addr),
        .wdata  (bus.load_data),
        .raddr  (pc_nxt),
        .rdata  (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            run      <= 1'b0;
            pc       <= '0;
            tgt_q    <= '0;
            op_q     <= OPC_OP;
            cond_q   <= COND_ALWAYS;
            flag_q   <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            valid_q <= 1'b0;
            unique case (state)
                ST_IDLE, ST_HALT: begin
                    if (bus.start || bus.step) begin
                        state    <= ST_FETCH;
                        run      <= bus.start;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    op_q   <= rd_op;
                    cond_q <= cond_e'(rdata[9:7]);
                    tgt_q  <= rdata[ADDR_W-1:0];
                    if (rd_op == OPC_OP) begin
                        valid_q <= 1'b1;
                        ctrl_q  <= rdata[CTRL_W-1:0];
                    end
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_q == OPC_OP) flag_q <= bus.flags_in;
                    if (op_q == OPC_HALT) begin
                        state    <= ST_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (run) begin
                        state <= ST_FETCH;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // reset kills an issuing op in the same cycle, not one cycle later
    assign bus.ctrl_valid = valid_q & ~reset;
    assign bus.ctrl_word  = ctrl_q;
    assign bus.pc         = pc;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: branch vector table plus
// hand sequences, issued control words checked through a scoreboard.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [9:0] sb [$];

    typedef struct {
        logic [2:0] cond;
        logic [5:0] flags;
        logic [4:0] exp_pc;
    } br_vec_t;

    br_vec_t vecs [15];

    instr_sequencer_if #(.ADDR_W(5)) bus ();

    instr_sequencer #(
        .PROG_DEPTH (32),
        .ADDR_W     (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every issued op must match the oldest expected word
    always @(negedge clk) begin
        if (!reset && bus.ctrl_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got ctrl_word %0h, no op expected",
                         bus.ctrl_word);
            end else begin
                check("sb_ctrl_word", {22'd0, bus.ctrl_word}, {22'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected TB_RESULT");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] fill_ctrl(input int a);
        return 10'((a * 19 + 3) % 1024);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [11:0] d);
        bus.load_we   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!bus.halted && n < 60) begin
            tick();
            n++;
        end
        check(name, {31'd0, bus.halted}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.ctrl_valid && n < 40) begin
            tick();
            n++;
        end
        check(name, {31'd0, bus.ctrl_valid}, 32'd1);
    endtask

    task automatic mid_reset(input string name);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check({name, "_valid_drop"}, {31'd0, bus.ctrl_valid}, 32'd0);
        tick();
        check({name, "_pc"}, {27'd0, bus.pc}, 32'd0);
        check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_halted"}, {31'd0, bus.halted}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [9:0] c;
        logic [7:0] vpat;
        int last;

        vecs[0]  = '{3'd0, 6'b000000, 5'd20};
        vecs[1]  = '{3'd1, 6'b100000, 5'd20};
        vecs[2]  = '{3'd1, 6'b000000, 5'd2};
        vecs[3]  = '{3'd2, 6'b100000, 5'd2};
        vecs[4]  = '{3'd2, 6'b011111, 5'd20};
        vecs[5]  = '{3'd3, 6'b010000, 5'd20};
        vecs[6]  = '{3'd3, 6'b101111, 5'd2};
        vecs[7]  = '{3'd4, 6'b010000, 5'd2};
        vecs[8]  = '{3'd4, 6'b101111, 5'd20};
        vecs[9]  = '{3'd5, 6'b000001, 5'd20};
        vecs[10] = '{3'd5, 6'b000010, 5'd2};
        vecs[11] = '{3'd6, 6'b000100, 5'd20};
        vecs[12] = '{3'd6, 6'b001000, 5'd2};
        vecs[13] = '{3'd7, 6'b001000, 5'd20};
        vecs[14] = '{3'd7, 6'b000100, 5'd2};

        bus.start     = 1'b0;
        bus.step      = 1'b0;
        bus.load_we   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.flags_in  = '0;
        reset         = 1'b1;
        tick();
        tick();
        tick();
        check("rst_pc", {27'd0, bus.pc}, 32'd0);
        check("rst_ctrl_word", {22'd0, bus.ctrl_word}, 32'd0);
        check("rst_ctrl_valid", {31'd0, bus.ctrl_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        reset = 1'b0;
        tick();

        // OP, OP, HALT with exact issue timing relative to start
        load_word(5'd0, 12'h206);
        load_word(5'd1, 12'h0C5);
        load_word(5'd2, 12'hC00);
        sb.push_back(10'h206);
        sb.push_back(10'h0C5);
        vpat = 8'b0001_0100;
        bus.start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid_t%0d", k), {31'd0, bus.ctrl_valid},
                  {31'd0, vpat[k]});
            if (k == 6) check("t1_busy_exec_halt", {31'd0, bus.busy}, 32'd1);
            if (k == 7) begin
                check("t1_halted", {31'd0, bus.halted}, 32'd1);
                check("t1_busy", {31'd0, bus.busy}, 32'd0);
                check("t1_pc", {27'd0, bus.pc}, 32'd2);
            end
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        check("t1_ctrl_hold", {22'd0, bus.ctrl_word}, 32'h0C5);

        // branch conditions against captured flags
        load_word(5'd2, 12'hC00);
        load_word(5'd20, 12'hC00);
        for (int i = 0; i < 15; i++) begin
            c = 10'(i * 41 + 7);
            load_word(5'd0, {2'b00, c});
            load_word(5'd1, {2'b01, vecs[i].cond, 2'b00, 5'd20});
            bus.flags_in = vecs[i].flags;
            sb.push_back(c);
            pulse_start();
            wait_valid($sformatf("br_op_valid[%0d]", i));
            tick();
            bus.flags_in = ~vecs[i].flags;
            wait_halted($sformatf("br_halt[%0d]", i));
            check($sformatf("br_pc[%0d]", i), {27'd0, bus.pc},
                  {27'd0, vecs[i].exp_pc});
        end
        bus.flags_in = '0;

        // single-step mode
        do_reset();
        load_word(5'd0, 12'h0F0);
        load_word(5'd1, 12'h30F);
        load_word(5'd2, 12'hC00);
        for (int s = 0; s < 2; s++) begin
            sb.push_back(s == 0 ? 10'h0F0 : 10'h30F);
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            tick();
            tick();
            check($sformatf("step%0d_busy", s), {31'd0, bus.busy}, 32'd0);
            check($sformatf("step%0d_halted", s), {31'd0, bus.halted}, 32'd0);
            check($sformatf("step%0d_pc", s), {27'd0, bus.pc}, s + 1);
            tick();
            tick();
        end
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        tick();
        check("step_halt_halted", {31'd0, bus.halted}, 32'd1);
        check("step_halt_pc", {27'd0, bus.pc}, 32'd2);
        sb.push_back(10'h0F0);
        sb.push_back(10'h30F);
        bus.start = 1'b1;
        bus.step  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.step  = 1'b0;
        check("start_step_pc0", {27'd0, bus.pc}, 32'd0);
        check("start_step_busy", {31'd0, bus.busy}, 32'd1);
        wait_halted("start_step_halt");
        check("start_step_pc", {27'd0, bus.pc}, 32'd2);

        // writes while busy are dropped
        load_word(5'd0, 12'h011);
        load_word(5'd1, 12'h80A);
        load_word(5'd10, 12'h155);
        load_word(5'd11, 12'hC00);
        sb.push_back(10'h011);
        sb.push_back(10'h155);
        pulse_start();
        bus.load_we   = 1'b1;
        bus.load_addr = 5'd10;
        bus.load_data = 12'h2AA;
        for (int k = 0; k < 5; k++) tick();
        bus.load_we = 1'b0;
        wait_halted("busy_wr_halt");
        check("busy_wr_pc", {27'd0, bus.pc}, 32'd11);
        sb.push_back(10'h011);
        sb.push_back(10'h155);
        pulse_start();
        wait_halted("busy_wr_readback_halt");

        // load and start in the same cycle: fetch sees the new word
        sb.push_back(10'h3C3);
        sb.push_back(10'h155);
        bus.load_we   = 1'b1;
        bus.load_addr = 5'd0;
        bus.load_data = 12'h3C3;
        bus.start     = 1'b1;
        tick();
        bus.load_we = 1'b0;
        bus.start   = 1'b0;
        wait_halted("load_start_halt");

        // memory full of OPs: free run with pc wrap, then reset mid-EXEC
        for (int a = 0; a < 32; a++) load_word(5'(a), {2'b00, fill_ctrl(a)});
        for (int k = 0; k < 36; k++) sb.push_back(fill_ctrl(k % 32));
        pulse_start();
        last = 0;
        for (int k = 0; k < 36; k++) begin
            wait_valid($sformatf("wrap_valid[%0d]", k));
            check($sformatf("wrap_pc[%0d]", k), {27'd0, bus.pc}, k % 32);
            if (k > 0) check($sformatf("wrap_gap[%0d]", k), cyc - last, 32'd2);
            last = cyc;
            if (k < 35) tick();
        end
        mid_reset("wrap_rst");

        // JMP loop without HALT, reset, then restart from intact program
        load_word(5'd0, 12'h101);
        load_word(5'd1, 12'h202);
        load_word(5'd2, 12'h800);
        for (int k = 0; k < 6; k++) sb.push_back(k % 2 == 0 ? 10'h101 : 10'h202);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            wait_valid($sformatf("jmp_valid[%0d]", k));
            check($sformatf("jmp_pc[%0d]", k), {27'd0, bus.pc}, k % 2);
            if (k < 5) tick();
        end
        mid_reset("jmp_rst");
        sb.push_back(10'h101);
        sb.push_back(10'h202);
        pulse_start();
        wait_valid("restart_valid0");
        tick();
        wait_valid("restart_valid1");
        check("restart_pc", {27'd0, bus.pc}, 32'd1);
        mid_reset("restart_rst");

        tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
